// File: rtl/mipi_csi2_capture_ctrl.sv
// Capture sequencer between host control and the CSI-2 deserializer (img_clk domain).
// Aligns capture to a clean frame start, forwards N whole frames, and guards the session with a watchdog.
module mipi_csi2_capture_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int TO_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           num_frames,
  input  logic [TO_WIDTH-1:0]  timeout,
  input  logic                 fvi,
  input  logic                 lvi,
  input  logic                 dvi,
  output logic                 des_enable,
  output logic                 cap_fvo,
  output logic                 cap_lvo,
  output logic                 cap_dvo,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [7:0]           frame_cnt,
  output logic [CNT_WIDTH-1:0] lines_last,
  output logic [CNT_WIDTH-1:0] linelen_last
);

  typedef enum logic [2:0] {IDLE, SYNC, ARMED, CAPTURE, DRAIN} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [TO_WIDTH-1:0]  TO_ONE  = {{(TO_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic                  fvi_d_q, lvi_d_q;
  logic [7:0]            nframes_q, nframes_d;
  logic [TO_WIDTH-1:0]   tlimit_q, tlimit_d;
  logic [TO_WIDTH-1:0]   wd_q, wd_d;
  logic [CNT_WIDTH-1:0]  lines_q, lines_d;
  logic [CNT_WIDTH-1:0]  pix_q, pix_d;
  logic [CNT_WIDTH-1:0]  lines_last_q, lines_last_d;
  logic [CNT_WIDTH-1:0]  linelen_q, linelen_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  cap_f_q, cap_l_q, cap_d_q;
  logic                  wd_fire;

  logic fvi_rise, fvi_fall, fvi_edge, lvi_rise, lvi_fall;
  logic active, gate;
  logic [7:0] frame_cnt_inc;

  assign fvi_rise      = fvi & ~fvi_d_q;
  assign fvi_fall      = ~fvi & fvi_d_q;
  assign fvi_edge      = fvi ^ fvi_d_q;
  assign lvi_rise      = lvi & ~lvi_d_q;
  assign lvi_fall      = ~lvi & lvi_d_q;
  assign active        = (state_q == CAPTURE) || (state_q == DRAIN);
  assign gate          = active || ((state_q == ARMED) && fvi_rise);
  assign frame_cnt_inc = frame_cnt_q + 8'd1;
  assign done_d        = (state_q != IDLE) && (state_d == IDLE);

  always_comb begin
    state_d      = state_q;
    nframes_d    = nframes_q;
    tlimit_d     = tlimit_q;
    wd_d         = wd_q;
    lines_d      = lines_q;
    pix_d        = pix_q;
    lines_last_d = lines_last_q;
    linelen_d    = linelen_q;
    frame_cnt_d  = frame_cnt_q;
    err_d        = err_q;
    wd_fire      = 1'b0;

    if (state_q == IDLE) begin
      if (start) begin
        state_d     = SYNC;
        nframes_d   = num_frames;
        tlimit_d    = timeout;
        frame_cnt_d = 8'd0;
        err_d       = 1'b0;
        wd_d        = '0;
      end
    end else begin
      // Watchdog fires on the cycle the quiet-cycle count reaches the limit.
      if (tlimit_q != '0) begin
        wd_d    = fvi_edge ? '0 : wd_q + TO_ONE;
        wd_fire = (wd_d == tlimit_q);
      end else begin
        wd_d = '0;
      end

      if (active) begin
        if (lvi_rise) begin
          lines_d = (lines_q == CNT_MAX) ? lines_q : lines_q + CNT_ONE;
          pix_d   = dvi ? CNT_ONE : '0;
        end else if (dvi && (pix_q != CNT_MAX)) begin
          pix_d = pix_q + CNT_ONE;
        end
        if (lvi_fall) linelen_d = pix_d;
        if (fvi_fall) begin
          frame_cnt_d  = frame_cnt_inc;
          lines_last_d = lines_d;
        end
      end

      if ((state_q == ARMED) && fvi_rise) begin
        lines_d = '0;
        pix_d   = '0;
      end

      if (wd_fire) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else if (abort) begin
        state_d = active ? DRAIN : IDLE;
      end else begin
        case (state_q)
          SYNC:    if (!fvi) state_d = ARMED;
          ARMED:   if (fvi_rise) state_d = CAPTURE;
          CAPTURE: if (fvi_fall) state_d = ((nframes_q != 8'd0) && (frame_cnt_inc == nframes_q)) ? IDLE : ARMED;
          DRAIN:   if (fvi_fall) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fvi_d_q      <= 1'b0;
      lvi_d_q      <= 1'b0;
      nframes_q    <= 8'd0;
      tlimit_q     <= '0;
      wd_q         <= '0;
      lines_q      <= '0;
      pix_q        <= '0;
      lines_last_q <= '0;
      linelen_q    <= '0;
      frame_cnt_q  <= 8'd0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      cap_f_q      <= 1'b0;
      cap_l_q      <= 1'b0;
      cap_d_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fvi_d_q      <= fvi;
      lvi_d_q      <= lvi;
      nframes_q    <= nframes_d;
      tlimit_q     <= tlimit_d;
      wd_q         <= wd_d;
      lines_q      <= lines_d;
      pix_q        <= pix_d;
      lines_last_q <= lines_last_d;
      linelen_q    <= linelen_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
      done_q       <= done_d;
      cap_f_q      <= fvi & gate;
      cap_l_q      <= lvi & gate;
      cap_d_q      <= dvi & gate;
    end
  end

  assign busy         = (state_q != IDLE);
  assign des_enable   = (state_q != IDLE);
  assign done         = done_q;
  assign timeout_err  = err_q;
  assign frame_cnt    = frame_cnt_q;
  assign lines_last   = lines_last_q;
  assign linelen_last = linelen_q;
  assign cap_fvo      = cap_f_q;
  assign cap_lvo      = cap_l_q;
  assign cap_dvo      = cap_d_q;

endmodule

// File: tb/tb_mipi_csi2_capture_ctrl.sv
// Bench for mipi_csi2_capture_ctrl: directed scenarios plus randomized sessions,
// every cycle compared against a session-level behavioural model.
module tb_mipi_csi2_capture_ctrl;

  localparam int CW      = 16;
  localparam int TW      = 24;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    numFrames = 8'd0;
  logic [TW-1:0] timeoutVal = '0;
  logic          fvi = 1'b0, lvi = 1'b0, dvi = 1'b0;

  logic          desEnable, capFvo, capLvo, capDvo, busy, done, timeoutErr;
  logic [7:0]    frameCnt;
  logic [CW-1:0] linesLast, linelenLast;

  mipi_csi2_capture_ctrl #(.CNT_WIDTH(CW), .TO_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_frames(numFrames), .timeout(timeoutVal),
    .fvi(fvi), .lvi(lvi), .dvi(dvi),
    .des_enable(desEnable), .cap_fvo(capFvo), .cap_lvo(capLvo), .cap_dvo(capDvo),
    .busy(busy), .done(done), .timeout_err(timeoutErr),
    .frame_cnt(frameCnt), .lines_last(linesLast), .linelen_last(linelenLast)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;
  int doneSeen   = 0;
  int capRises   = 0;
  logic prevCapF = 1'b0;
  bit randAbortEn = 1'b0;

  // Session-level model: in a session, waiting for a quiet fvi, then either between frames or inside a captured frame.
  bit mBusy, mSeenQuiet, mInFrame, mStopAtEnd, mPrevF, mPrevL;
  int mTarget, mLimit, mQuiet, mLines, mPix;
  bit eCapF, eCapL, eCapD, eDone, eErr;
  int eFrameCnt, eLinesLast, eLinelen;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      if (errorCount <= 40)
        $display("[TB] FAIL %s at %0t: got %0h, wanted %0h", name, $time, actual, expected);
    end
  endtask

  function automatic void modelReset();
    mBusy = 0; mSeenQuiet = 0; mInFrame = 0; mStopAtEnd = 0; mPrevF = 0; mPrevL = 0;
    mTarget = 0; mLimit = 0; mQuiet = 0; mLines = 0; mPix = 0;
    eCapF = 0; eCapL = 0; eCapD = 0; eDone = 0; eErr = 0;
    eFrameCnt = 0; eLinesLast = 0; eLinelen = 0;
  endfunction

  function automatic void modelStep();
    bit fRise = fvi && !mPrevF;
    bit fFall = !fvi && mPrevF;
    bit lRise = lvi && !mPrevL;
    bit lFall = !lvi && mPrevL;
    bit capturing = mBusy && mInFrame;
    bit waitingFrame = mBusy && mSeenQuiet && !mInFrame;
    bit passThrough = capturing || (waitingFrame && fRise);
    bit dog = 0;
    bit endSession = 0;
    eCapF = fvi && passThrough;
    eCapL = lvi && passThrough;
    eCapD = dvi && passThrough;
    eDone = 0;
    if (!mBusy) begin
      if (start) begin
        mBusy = 1; mSeenQuiet = 0; mInFrame = 0; mStopAtEnd = 0;
        mTarget = numFrames; mLimit = int'(timeoutVal); mQuiet = 0;
        eFrameCnt = 0; eErr = 0;
      end
    end else begin
      if (mLimit != 0) begin
        mQuiet = (fRise || fFall) ? 0 : mQuiet + 1;
        dog = (mQuiet == mLimit);
      end
      if (capturing) begin
        if (lRise) begin
          if (mLines < CNT_SAT) mLines++;
          mPix = dvi ? 1 : 0;
        end else if (dvi && mPix < CNT_SAT) begin
          mPix++;
        end
        if (lFall) eLinelen = mPix;
        if (fFall) begin
          eFrameCnt = (eFrameCnt + 1) % 256;
          eLinesLast = mLines;
        end
      end
      if (dog) begin
        endSession = 1; eErr = 1;
      end else if (abort) begin
        if (capturing) mStopAtEnd = 1;
        else endSession = 1;
      end else if (!mSeenQuiet) begin
        if (!fvi) mSeenQuiet = 1;
      end else if (!mInFrame) begin
        if (fRise) begin mInFrame = 1; mLines = 0; mPix = 0; end
      end else if (fFall) begin
        if (mStopAtEnd || (mTarget != 0 && eFrameCnt == mTarget)) endSession = 1;
        else mInFrame = 0;
      end
      if (endSession) begin mBusy = 0; mInFrame = 0; eDone = 1; end
    end
    mPrevF = fvi;
    mPrevL = lvi;
  endfunction

  always @(posedge clk) begin
    if (reset) modelReset();
    else modelStep();
    #1;
    checkOutput("cap_fvo", capFvo, eCapF);
    checkOutput("cap_lvo", capLvo, eCapL);
    checkOutput("cap_dvo", capDvo, eCapD);
    checkOutput("busy", busy, mBusy);
    checkOutput("des_enable", desEnable, mBusy);
    checkOutput("done", done, eDone);
    checkOutput("timeout_err", timeoutErr, eErr);
    checkOutput("frame_cnt", frameCnt, eFrameCnt);
    checkOutput("lines_last", linesLast, eLinesLast);
    checkOutput("linelen_last", linelenLast, eLinelen);
    if (done === 1'b1) doneSeen++;
    if (capFvo === 1'b1 && prevCapF !== 1'b1) capRises++;
    prevCapF = capFvo;
  end

  task automatic applyStimulus(input logic f, input logic l, input logic d, input logic s, input logic a);
    @(negedge clk);
    fvi = f; lvi = l; dvi = d; start = s;
    abort = a | (randAbortEn && ($urandom_range(0, 149) == 0));
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendFrame(input int nLines, input int len, input bit dense, input int abortLine);
    idleCycles(2);
    repeat ($urandom_range(1, 3)) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int ln = 0; ln < nLines; ln++) begin
      for (int px = 0; px < len; px++)
        applyStimulus(1'b1, 1'b1, dense ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, (ln == abortLine) && (px == 0));
      repeat ($urandom_range(1, 2)) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("idle within budget", busy, 1'b0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int d0, r0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset des_enable", desEnable, 1'b0);
    checkOutput("reset cap_fvo", capFvo, 1'b0);
    checkOutput("reset frame_cnt", frameCnt, 8'd0);
    checkOutput("reset timeout_err", timeoutErr, 1'b0);
    reset = 1'b0;

    // Single frame: 4 lines of 10 pixels.
    numFrames = 8'd1; timeoutVal = '0;
    d0 = doneSeen; r0 = capRises;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("start busy", busy, 1'b1);
    checkOutput("start des_enable", desEnable, 1'b1);
    sendFrame(4, 10, 1'b1, -1);
    idleCycles(3);
    checkOutput("single frame_cnt", frameCnt, 8'd1);
    checkOutput("single lines_last", linesLast, 16'd4);
    checkOutput("single linelen_last", linelenLast, 16'd10);
    checkOutput("model lines_last", eLinesLast, 4);
    checkOutput("model linelen_last", eLinelen, 10);
    checkOutput("single des_enable after", desEnable, 1'b0);
    checkOutput("single done count", doneSeen - d0, 1);
    checkOutput("single cap frames", capRises - r0, 1);

    // Start mid-frame: the partial frame is skipped, two whole frames follow.
    numFrames = 8'd2;
    d0 = doneSeen; r0 = capRises;
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    sendFrame(3, 4, 1'b1, -1);
    sendFrame(2, 5, 1'b1, -1);
    waitIdle(50);
    checkOutput("skip frame_cnt", frameCnt, 8'd2);
    checkOutput("skip cap frames", capRises - r0, 2);
    checkOutput("skip done count", doneSeen - d0, 1);

    // Abort during line 2 drains frame 1 to its end.
    numFrames = 8'd0;
    d0 = doneSeen; r0 = capRises;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    sendFrame(4, 5, 1'b1, 1);
    idleCycles(2);
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort frame_cnt", frameCnt, 8'd1);
    checkOutput("abort lines_last", linesLast, 16'd4);
    checkOutput("abort done count", doneSeen - d0, 1);
    sendFrame(2, 3, 1'b1, -1);
    checkOutput("abort no more cap", capRises - r0, 1);

    // Abort while waiting for a frame.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("armed abort done", done, 1'b1);
    checkOutput("armed abort frame_cnt", frameCnt, 8'd0);
    checkOutput("armed abort busy", busy, 1'b0);

    // Watchdog: 100 quiet cycles after entering SYNC.
    numFrames = 8'd1; timeoutVal = 24'd100;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (100) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("timeout early done", done, 1'b0);
    checkOutput("timeout early err", timeoutErr, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("timeout done", done, 1'b1);
    checkOutput("timeout err", timeoutErr, 1'b1);
    checkOutput("timeout busy", busy, 1'b0);
    timeoutVal = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("restart clears err", timeoutErr, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    waitIdle(5);

    // Continuous mode across the 8-bit wrap.
    numFrames = 8'd0;
    d0 = doneSeen;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (257) sendFrame(1, 2, 1'b1, -1);
    idleCycles(2);
    checkOutput("wrap frame_cnt", frameCnt, 8'd1);
    checkOutput("wrap busy", busy, 1'b1);
    checkOutput("wrap no done", doneSeen - d0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    waitIdle(5);

    // Asynchronous reset mid-frame.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycles(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("pre-reset cap_fvo", capFvo, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("async reset cap_fvo", capFvo, 1'b0);
    checkOutput("async reset cap_lvo", capLvo, 1'b0);
    checkOutput("async reset cap_dvo", capDvo, 1'b0);
    checkOutput("async reset busy", busy, 1'b0);
    checkOutput("async reset des_enable", desEnable, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    r0 = capRises;
    sendFrame(2, 3, 1'b1, -1);
    sendFrame(2, 3, 1'b1, -1);
    checkOutput("post-reset no cap", capRises - r0, 0);
    checkOutput("post-reset busy", busy, 1'b0);

    // Randomized sessions.
    for (int s = 0; s < 12; s++) begin
      numFrames   = 8'($urandom_range(0, 3));
      timeoutVal  = ($urandom_range(0, 2) == 0) ? TW'($urandom_range(25, 60)) : '0;
      randAbortEn = ($urandom_range(0, 1) == 1);
      applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, 1'b0);
      repeat ($urandom_range(2, 5))
        sendFrame($urandom_range(1, 4), $urandom_range(1, 6), 1'b0, -1);
      randAbortEn = 1'b0;
      if (busy) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      waitIdle(20);
    end

    idleCycles(2);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mipi_csi2_capture_ctrl.md
# mipi_csi2_capture_ctrl

Capture sequencer that sits between host control registers and the CSI-2 deserializer in the `img_clk` domain. It enables the deserializer on command and aligns capture to a clean frame start, discarding any partial frame in progress. It forwards exactly `num_frames` whole frames (or runs continuously), supports a clean abort at a frame boundary, and enforces a watchdog timeout. It also reports frame, line-count and line-length statistics.

## Interface

Reset is asynchronous, active-high.

Parameters:
- `CNT_WIDTH`, 16: width of line-count and line-length counters.
- `TO_WIDTH`, 24: width of the timeout counter and `timeout` input.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, deserializer `img_clk`.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle command pulse; honoured only in IDLE.
- `abort` in 1: one-cycle command pulse; honoured only outside IDLE.
- `num_frames` in 8: frames to capture; 0 means continuous. Sampled on `start`.
- `timeout` in `TO_WIDTH`: watchdog limit in cycles without an `fvi` edge; 0 disables. Sampled on `start`.
- `fvi`, `lvi`, `dvi` in 1 each: frame, line and data valid from the deserializer.
- `des_enable` out 1: deserializer enable.
- `cap_fvo`, `cap_lvo`, `cap_dvo` out 1 each: gated, registered copies of `fvi`, `lvi`, `dvi`.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse on every return to IDLE.
- `timeout_err` out 1: sticky; cleared on accepted `start`.
- `frame_cnt` out 8: frames completed since `start`; wraps modulo 256.
- `lines_last` out `CNT_WIDTH`: line count of the last completed frame.
- `linelen_last` out `CNT_WIDTH`: `dvi` cycles in the last completed line.

## Operation

Edge detection:
- `fvi_d` and `lvi_d` are 1-cycle registered copies of `fvi` and `lvi`.
- Rising edge: `x & !x_d`. Falling edge: `!x & x_d`.

State machine (IDLE, SYNC, ARMED, CAPTURE, DRAIN):
- IDLE: `des_enable`=0.
  - On `start`: latch `num_frames` and `timeout`; clear `frame_cnt` and `timeout_err`; go to SYNC.
  - `abort` is ignored.
- SYNC: wait for `fvi`=0 to skip any partial frame; then go to ARMED.
- ARMED: on `fvi` rising edge, go to CAPTURE and clear the running line and pixel counters.
- CAPTURE: on `fvi` falling edge:
  - Increment `frame_cnt` and latch the running line count into `lines_last`.
  - If `num_frames`≠0 and the incremented count equals `num_frames`: go to IDLE and pulse `done`.
  - Otherwise go to ARMED.
  - On `abort`: go to DRAIN.
- DRAIN: identical to CAPTURE, except the `fvi` falling edge always goes to IDLE with `done`. The drained frame is counted.
- `abort` in SYNC or ARMED: go to IDLE and pulse `done` in the next cycle. `frame_cnt` is unchanged.
- `des_enable`=1 in every state except IDLE.

Gating:
- `gate` = (state is CAPTURE or DRAIN) or (state is ARMED and `fvi` rising edge).
- Each cycle, `cap_x <= x & gate` for `x` in {`fvi`, `lvi`, `dvi`}.
- Frames that start before ARMED, or after the final frame, never appear on the `cap_*` outputs.

Statistics (CAPTURE and DRAIN only):
- Running line counter increments on each `lvi` rising edge.
- Running pixel counter increments on each cycle with `dvi`=1 and is cleared on each `lvi` rising edge.
- On `lvi` falling edge, the pixel counter value (including a `dvi` in that cycle) is latched into `linelen_last`.
- Both running counters saturate at all-ones and never wrap.

Watchdog (`timeout`≠0, any non-IDLE state):
- Counter is cleared on any `fvi` edge and on entry to SYNC; it increments otherwise.
- When the counter equals `timeout`: set `timeout_err`, go to IDLE, pulse `done`.
- Watchdog takes priority over a simultaneous `abort` or frame-end. A frame-end in that cycle is still counted.

Priority within a cycle: watchdog > `abort` > `fvi` edge transitions.

## Timing

- Reset values: all outputs 0; state IDLE; all counters 0.
- `start` at cycle t: `busy`=1 and `des_enable`=1 at t+1.
- Capture latency: `cap_*` follow `fvi`/`lvi`/`dvi` by exactly 1 cycle.
- First `fvi` high (in ARMED) at cycle t: `cap_fvo`=1 at t+1.
- Final `fvi` falling edge at cycle t: state IDLE, `done`=1, `busy`=0, updated `frame_cnt` and `lines_last`, all at t+1. `cap_fvo`=0 at t+1.
- `done` is high for exactly one cycle per capture session.
- `reset` asserted mid-frame: all outputs drop to 0 immediately (asynchronous). After release the block stays in IDLE until a new `start`.

## Test plan

- **Single frame:** `num_frames`=1, `start` with `fvi` low; one frame of 4 lines × 10 `dvi` → `cap_*` is a 1-cycle-delayed copy; `frame_cnt`=1, `lines_last`=4, `linelen_last`=10; `done` pulses once; `des_enable`=0 afterwards.
- **Partial-frame skip:** `start` while `fvi`=1 mid-frame, `num_frames`=2 → the partial frame is not forwarded; the next two full frames are forwarded; `frame_cnt`=2.
- **Abort:** `abort` during line 2 of frame 1 with `num_frames`=0 → frame 1 is forwarded to its end; IDLE at frame end +1; `frame_cnt`=1; no further `cap_fvo`. `abort` in ARMED → `done` next cycle, `frame_cnt`=0.
- **Timeout:** `timeout`=100, `fvi` held low after `start` → `timeout_err`=1 and `done` exactly 100 cycles after SYNC entry. The next `start` clears `timeout_err`.
- **Continuous wrap:** `num_frames`=0, 257 frames → `frame_cnt`=1, `busy` still 1, no `done`.
- **Reset mid-operation:** assert `reset` in CAPTURE → all outputs 0 in the same cycle. After release, frames on `fvi` produce no `cap_fvo` until `start`.
